drd_result_rx: RTL



---
 rtl/drd_result_rx_if.sv | 22 ++
 rtl/drd_result_rx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/drd_result_rx_if.sv
// rtl/drd_result_rx_if.sv - dual-rail result bus and single-ended output handshake (DRD_RX_PARITY_EN adds the parity pair)
interface drd_result_rx_if #(
  parameter int W = 32
);
  logic [W-1:0] y;
  logic [W-1:0] yn;
`ifdef DRD_RX_PARITY_EN
  logic         y_par;
  logic         yn_par;
`endif
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

`ifdef DRD_RX_PARITY_EN
  modport master (output y, yn, y_par, yn_par, out_ready, input out_data, out_valid);
  modport slave  (input y, yn, y_par, yn_par, out_ready, output out_data, out_valid);
`else
  modport master (output y, yn, out_ready, input out_data, out_valid);
  modport slave  (input y, yn, out_ready, output out_data, out_valid);
`endif
endinterface

// File: rtl/drd_result_rx.sv
// rtl/drd_result_rx.sv - dual-rail result receiver with completion FSM and FWFT output FIFO (optional DRD_RX_PARITY_EN)
module drd_result_rx #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int TMO   = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  drd_result_rx_if.slave bus,
  output logic           err_ill,
  output logic           err_tmo,
  output logic           err_ovf,
`ifdef DRD_RX_PARITY_EN
  output logic           err_par,
`endif
  input  logic           err_clr,
  output logic           busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [7:0]  TMO_CNT  = 8'(TMO);

  localparam logic [1:0] ST_SPACER   = 2'd0;
  localparam logic [1:0] ST_PARTIAL  = 2'd1;
  localparam logic [1:0] ST_COMPLETE = 2'd2;
  localparam logic [1:0] ST_DRAIN    = 2'd3;

  logic [W-1:0]  yr;
  logic [W-1:0]  ynr;
`ifdef DRD_RX_PARITY_EN
  logic          yr_par;
  logic          ynr_par;
`endif
  logic [1:0]    state;
  logic [7:0]    cnt;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic [W-1:0]  out_data_q;

  logic allsp;
  logic allv;
  logic ill;
  logic par_ok;
  logic evaluating;
  logic accept;
  logic full;
  logic pop;
  logic push;
  logic ovf_evt;
  logic ill_evt;
  logic tmo_evt;

  // Register the raw rails; all classification looks only at this copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yr  <= '0;
      ynr <= '0;
`ifdef DRD_RX_PARITY_EN
      yr_par  <= 1'b0;
      ynr_par <= 1'b0;
`endif
    end else begin
      yr  <= bus.y;
      ynr <= bus.yn;
`ifdef DRD_RX_PARITY_EN
      yr_par  <= bus.y_par;
      ynr_par <= bus.yn_par;
`endif
    end
  end

  // Word classification: spacer=00, valid=01/10, illegal=11 per rail pair
  always_comb begin
    allsp  = ~|(yr | ynr);
    allv   = &(yr ^ ynr);
    ill    = |(yr & ynr);
`ifdef DRD_RX_PARITY_EN
    allsp  = allsp & ~(yr_par | ynr_par);
    allv   = allv & (yr_par ^ ynr_par);
    ill    = ill | (yr_par & ynr_par);
    par_ok = ~(^yr ^ yr_par);
`else
    par_ok = 1'b1;
`endif
  end

  // The push decision is committed on the edge that enters COMPLETE, so a
  // codeword lands in the FIFO one edge after it is registered.
  assign evaluating = (state == ST_SPACER) || (state == ST_PARTIAL);
  assign accept     = evaluating && !ill && allv;
  assign full       = (count == FULL_CNT);
  assign pop        = bus.out_valid && bus.out_ready;
  assign push       = accept && par_ok && (!full || pop);
  assign ovf_evt    = accept && par_ok && full && !pop;
  assign ill_evt    = evaluating && ill;
  assign tmo_evt    = (state == ST_PARTIAL) && !ill && !allv && (cnt == TMO_CNT);

  // Completion FSM with partial-word timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_SPACER;
      cnt   <= 8'd0;
    end else begin
      case (state)
        ST_SPACER: begin
          if (ill) begin
            state <= ST_SPACER;
          end else if (allv) begin
            state <= ST_COMPLETE;
          end else if (!allsp) begin
            state <= ST_PARTIAL;
            cnt   <= 8'd0;
          end
        end
        ST_PARTIAL: begin
          if (ill) begin
            state <= ST_DRAIN;
          end else if (allv) begin
            state <= ST_COMPLETE;
          end else if (cnt == TMO_CNT) begin
            state <= ST_DRAIN;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_COMPLETE: state <= ST_DRAIN;
        default: begin
          if (allsp) state <= ST_SPACER;
        end
      endcase
    end
  end

  // Sticky error flags; a new event in the same cycle beats err_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ill <= 1'b0;
      err_tmo <= 1'b0;
      err_ovf <= 1'b0;
`ifdef DRD_RX_PARITY_EN
      err_par <= 1'b0;
`endif
    end else begin
      err_ill <= (err_ill & ~err_clr) | ill_evt;
      err_tmo <= (err_tmo & ~err_clr) | tmo_evt;
      err_ovf <= (err_ovf & ~err_clr) | ovf_evt;
`ifdef DRD_RX_PARITY_EN
      err_par <= (err_par & ~err_clr) | (accept & ~par_ok);
`endif
    end
  end

  // Next read pointer and occupancy
  always_comb begin
    rd_next    = pop ? rd_ptr + 1'b1 : rd_ptr;
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // FIFO storage; contents need no reset since reads are gated by occupancy
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= yr;
  end

  // FIFO pointers and a registered head so out_data holds when the FIFO empties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_data_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_next;
      count  <= count_next;
      if (count_next != '0) begin
        out_data_q <= (push && (rd_next == wr_ptr)) ? yr : mem[rd_next];
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = (count != '0);
  assign busy          = (state != ST_SPACER);

endmodule
